// File: rtl/pipe_ctrl.sv
// Beta pipeline sequencing controller: PC source / IR source selection,
// interrupt synchronisation with hold-off, and saturating stall/annul counters.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_RESET | force reset vector into fetch PC, both IR stages fed NOPs
// S_RUN   | normal sequencing from decode-stage status
module pipe_ctrl #(
  parameter int HOLDOFF = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             op_jmp,
  input  logic             op_beq,
  input  logic             op_bne,
  input  logic             zr,
  input  logic             illop,
  input  logic             pc_dec_sup,
  input  logic             irq,
  output logic [2:0]       pc_sel,
  output logic             pc_we,
  output logic [1:0]       ir_src_if,
  output logic [1:0]       ir_src_dec,
  output logic             irq_ack,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] annul_cnt
);

  localparam logic [1:0] IR_SRC_DATA   = 2'd0;
  localparam logic [1:0] IR_SRC_NOP    = 2'd1;
  localparam logic [1:0] IR_SRC_EXCEPT = 2'd2;

  localparam logic [2:0] PC_SEL_INC    = 3'd0;
  localparam logic [2:0] PC_SEL_BR     = 3'd1;
  localparam logic [2:0] PC_SEL_JMP    = 3'd2;
  localparam logic [2:0] PC_SEL_ILLOP  = 3'd3;
  localparam logic [2:0] PC_SEL_IRQ    = 3'd4;
  localparam logic [2:0] PC_SEL_RESET  = 3'd5;

  localparam int HW = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  typedef enum logic {S_RESET, S_RUN} state_t;

  state_t        state;
  logic          irq_s1, irq_s2, irq_prev;
  logic          pending;
  logic [HW-1:0] holdoff;
  logic          irq_edge;
  logic          irq_ok;
  logic          taken;

  assign irq_edge = irq_s2 & ~irq_prev;
  assign irq_ok   = pending & ~pc_dec_sup & (holdoff == '0);
  assign taken    = op_jmp | (op_beq & zr) | (op_bne & ~zr);

  // Decisions are combinational so a redirect takes effect in the same cycle
  // the decode stage presents the instruction.
  always_comb begin
    pc_sel     = PC_SEL_RESET;
    pc_we      = 1'b1;
    ir_src_if  = IR_SRC_NOP;
    ir_src_dec = IR_SRC_NOP;
    irq_ack    = 1'b0;
    if (state == S_RUN) begin
      if (stall) begin
        pc_sel     = PC_SEL_INC;
        pc_we      = 1'b0;
        ir_src_if  = IR_SRC_DATA;
        ir_src_dec = IR_SRC_NOP;
      end else if (illop) begin
        pc_sel     = PC_SEL_ILLOP;
        ir_src_if  = IR_SRC_NOP;
        ir_src_dec = IR_SRC_EXCEPT;
      end else if (irq_ok) begin
        pc_sel     = PC_SEL_IRQ;
        ir_src_if  = IR_SRC_NOP;
        ir_src_dec = IR_SRC_EXCEPT;
        irq_ack    = 1'b1;
      end else if (taken) begin
        pc_sel     = op_jmp ? PC_SEL_JMP : PC_SEL_BR;
        ir_src_if  = IR_SRC_NOP;
        ir_src_dec = IR_SRC_DATA;
      end else begin
        pc_sel     = PC_SEL_INC;
        ir_src_if  = IR_SRC_DATA;
        ir_src_dec = IR_SRC_DATA;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_RESET;
      irq_s1    <= 1'b0;
      irq_s2    <= 1'b0;
      irq_prev  <= 1'b0;
      pending   <= 1'b0;
      holdoff   <= '0;
      stall_cnt <= '0;
      annul_cnt <= '0;
    end else begin
      state    <= S_RUN;
      irq_s1   <= irq;
      irq_s2   <= irq_s1;
      irq_prev <= irq_s2;

      // A fresh edge wins over the clear so a back-to-back request is not lost.
      if (irq_edge)
        pending <= 1'b1;
      else if (irq_ack)
        pending <= 1'b0;

      if (irq_ack)
        holdoff <= HW'(HOLDOFF);
      else if (state == S_RUN && holdoff != '0)
        holdoff <= holdoff - HW'(1);

      if (state == S_RUN && stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (state == S_RUN && ir_src_if == IR_SRC_NOP && annul_cnt != '1)
        annul_cnt <= annul_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (HOLDOFF=4, CNT_W=4).
module tb_pipe_ctrl;

  localparam logic [1:0] DATA = 2'd0, NOP = 2'd1, EXC = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stall = 0, op_jmp = 0, op_beq = 0, op_bne = 0, zr = 0;
  logic       illop = 0, pc_dec_sup = 0, irq = 0;
  logic [2:0] pc_sel;
  logic       pc_we;
  logic [1:0] ir_src_if, ir_src_dec;
  logic       irq_ack;
  logic [3:0] stall_cnt, annul_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pipe_ctrl #(.HOLDOFF(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .op_jmp(op_jmp), .op_beq(op_beq),
    .op_bne(op_bne), .zr(zr), .illop(illop), .pc_dec_sup(pc_dec_sup), .irq(irq),
    .pc_sel(pc_sel), .pc_we(pc_we), .ir_src_if(ir_src_if), .ir_src_dec(ir_src_dec),
    .irq_ack(irq_ack), .stall_cnt(stall_cnt), .annul_cnt(annul_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] sel, input logic we,
                         input logic [1:0] sif, input logic [1:0] sdec, input logic ack);
    check({tag, ".pc_sel"},     32'(pc_sel),     32'(sel));
    check({tag, ".pc_we"},      32'(pc_we),      32'(we));
    check({tag, ".ir_src_if"},  32'(ir_src_if),  32'(sif));
    check({tag, ".ir_src_dec"}, 32'(ir_src_dec), 32'(sdec));
    check({tag, ".irq_ack"},    32'(irq_ack),    32'(ack));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; op_jmp = 0; op_beq = 0; op_bne = 0; zr = 0;
    illop = 0; pc_dec_sup = 0; irq = 0;
  endtask

  // Hold reset for 3 cycles, release, and leave the DUT in its first S_RUN cycle.
  task automatic do_reset();
    clear_inputs();
    #1 rst = 0;
    repeat (3) cyc();
    #1;
    chk_out("rst_held", 3'd5, 1'b1, NOP, NOP, 1'b0);
    check("rst_held.stall_cnt", 32'(stall_cnt), 0);
    check("rst_held.annul_cnt", 32'(annul_cnt), 0);
    rst = 1;
    #1;
    chk_out("s_reset", 3'd5, 1'b1, NOP, NOP, 1'b0);
    cyc();
    #1;
    chk_out("s_run0", 3'd0, 1'b1, DATA, DATA, 1'b0);
    check("s_run0.stall_cnt", 32'(stall_cnt), 0);
    check("s_run0.annul_cnt", 32'(annul_cnt), 0);
  endtask

  initial begin
    // Branch decisions
    do_reset();
    op_beq = 1; zr = 1; #1;
    chk_out("beq_taken", 3'd1, 1'b1, NOP, DATA, 1'b0);
    cyc(); clear_inputs(); #1;
    check("beq_taken.annul_cnt", 32'(annul_cnt), 1);
    op_bne = 1; zr = 1; #1;
    chk_out("bne_not_taken", 3'd0, 1'b1, DATA, DATA, 1'b0);
    cyc(); clear_inputs(); #1;
    check("bne_not_taken.annul_cnt", 32'(annul_cnt), 1);
    op_jmp = 1; #1;
    chk_out("jmp", 3'd2, 1'b1, NOP, DATA, 1'b0);
    cyc(); clear_inputs(); #1;
    check("jmp.annul_cnt", 32'(annul_cnt), 2);
    op_bne = 1; zr = 0; #1;
    chk_out("bne_taken", 3'd1, 1'b1, NOP, DATA, 1'b0);
    cyc(); clear_inputs(); #1;
    check("bne_taken.annul_cnt", 32'(annul_cnt), 3);

    // Stall overrides jump and illop; illop then taken
    stall = 1; op_jmp = 1; illop = 1; #1;
    chk_out("stall1", 3'd0, 1'b0, DATA, NOP, 1'b0);
    cyc(); #1;
    chk_out("stall2", 3'd0, 1'b0, DATA, NOP, 1'b0);
    cyc();
    stall = 0; op_jmp = 0; #1;
    check("stall.stall_cnt", 32'(stall_cnt), 2);
    check("stall.annul_cnt", 32'(annul_cnt), 3);
    chk_out("illop", 3'd3, 1'b1, NOP, EXC, 1'b0);
    cyc(); clear_inputs(); #1;
    check("illop.annul_cnt", 32'(annul_cnt), 4);

    // IRQ latency and hold-off: rise in c0, take in c3, second rise c4, take c8
    do_reset();
    irq = 1; cyc();
    irq = 0; #1;
    chk_out("irq_c1", 3'd0, 1'b1, DATA, DATA, 1'b0);
    cyc(); #1;
    chk_out("irq_c2", 3'd0, 1'b1, DATA, DATA, 1'b0);
    cyc(); #1;
    chk_out("irq_c3_take", 3'd4, 1'b1, NOP, EXC, 1'b1);
    cyc();
    irq = 1;
    for (int c = 4; c <= 7; c++) begin
      #1;
      check($sformatf("holdoff_c%0d.irq_ack", c), 32'(irq_ack), 0);
      cyc();
    end
    #1;
    chk_out("irq_c8_take", 3'd4, 1'b1, NOP, EXC, 1'b1);
    cyc(); irq = 0; #1;
    check("irq_c9.irq_ack", 32'(irq_ack), 0);

    // Supervisor masking, illop priority over irq, pending across stall
    do_reset();
    pc_dec_sup = 1; irq = 1;
    for (int c = 0; c < 20; c++) begin
      #1;
      check($sformatf("sup_mask_c%0d.irq_ack", c), 32'(irq_ack), 0);
      cyc();
    end
    pc_dec_sup = 0; #1;
    chk_out("sup_drop_take", 3'd4, 1'b1, NOP, EXC, 1'b1);
    cyc(); irq = 0;
    repeat (8) cyc();
    irq = 1;
    repeat (3) cyc();
    illop = 1; #1;
    chk_out("illop_vs_irq", 3'd3, 1'b1, NOP, EXC, 1'b0);
    cyc();
    illop = 0; stall = 1; #1;
    chk_out("stall_vs_irq", 3'd0, 1'b0, DATA, NOP, 1'b0);
    cyc();
    stall = 0; #1;
    chk_out("irq_after_illop", 3'd4, 1'b1, NOP, EXC, 1'b1);
    cyc(); irq = 0;

    // Saturation and asynchronous reset mid-stall
    do_reset();
    stall = 1;
    repeat (20) cyc();
    #1;
    check("sat.stall_cnt", 32'(stall_cnt), 15);
    rst = 0; #1;
    check("midrst.stall_cnt", 32'(stall_cnt), 0);
    check("midrst.annul_cnt", 32'(annul_cnt), 0);
    chk_out("midrst", 3'd5, 1'b1, NOP, NOP, 1'b0);
    cyc(); clear_inputs();
    rst = 1;
    cyc(); #1;
    chk_out("post_midrst", 3'd0, 1'b1, DATA, DATA, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
